uart_tx_ctrl: RTL and testbench

- Transmit-side sequencer for the full-duplex UART.
- Accepts a parallel byte through a valid/ready handshake and drives the serial line: start bit, DATA_W data bits LSB first, optional parity, then STOP_BITS stop bits.
- Owns the baud-tick divider, transmit shift register and bit counter; the counter wraps at DATA_W and is enabled only on baud ticks in DATA state.
- Sits between the host-side register/FIFO logic and the txd pin.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_baud_gen.sv | 25 ++
 rtl/uart_tx_ctrl.sv | 107 ++++++++++
 tb/tb_uart_tx_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, default divider and idle line level.
// Used by both the TX controller and the future RX controller.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

    localparam int   CLK_DIV_DEFAULT = 434;  // 50 MHz / 115200
    localparam logic LINE_IDLE       = 1'b1;
endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: counts 0..CLK_DIV-1 while enabled, one-cycle tick on the last count.
// The counter is held at zero while disabled so every bit starts on a fresh period.
module uart_baud_gen #(
    parameter int CLK_DIV = 434
)(
    input  logic inClk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge inClk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (!en || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to add the PARITY state and the parOdd input.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEFAULT,
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
)(
    input  logic                         inClk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            txData,
    input  logic                         txValid,
`ifdef UART_TX_PARITY_EN
    input  logic                         parOdd,
`endif
    output logic                         txReady,
    output logic                         txBusy,
    output logic                         txOut,
    output logic [$clog2(DATA_W+1)-1:0]  bitCnt
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    uart_state_e       state, state_nxt;
    logic [DATA_W-1:0] shift;
    logic              stop_cnt;
    logic              tick, accept, last_bit, last_stop;
`ifdef UART_TX_PARITY_EN
    logic              par;
`endif

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .inClk (inClk),
        .rst   (rst),
        .en    (state != IDLE),
        .tick  (tick)
    );

    assign accept    = txValid && (state == IDLE);
    assign last_bit  = (bitCnt == CNT_W'(DATA_W - 1));
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

    always_ff @(posedge inClk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = START;
            START:   if (tick) state_nxt = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:    if (tick && last_bit) state_nxt = PARITY;
            PARITY:  if (tick) state_nxt = STOP;
`else
            DATA:    if (tick && last_bit) state_nxt = STOP;
`endif
            STOP:    if (tick && last_stop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Byte is captured once at the handshake; txData is ignored for the rest of the frame.
    always_ff @(posedge inClk or negedge rst) begin
        if (!rst) begin
            shift    <= '0;
            bitCnt   <= '0;
            stop_cnt <= 1'b0;
        end else begin
            if (accept)
                shift <= txData;
            else if (state == DATA && tick)
                shift <= shift >> 1;
            if (state == DATA && tick)
                bitCnt <= last_bit ? '0 : bitCnt + CNT_W'(1);
            if (state == STOP && tick)
                stop_cnt <= last_stop ? 1'b0 : 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge inClk or negedge rst) begin
        if (!rst)
            par <= 1'b0;
        else if (accept)
            par <= ^txData;
    end
`endif

    // Line level is decoded from state so an async reset releases the pin at once.
    always_comb begin
        txOut = LINE_IDLE;
        case (state)
            START:   txOut = 1'b0;
            DATA:    txOut = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txOut = par ^ parOdd;
`endif
            default: txOut = LINE_IDLE;
        endcase
        txReady = (state == IDLE);
        txBusy  = (state != IDLE);
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: dut0 has one stop bit, dut1 has two.
// Stimulus pushes expected frames; the monitor checks the line cycle by cycle.
module tb_uart_tx_ctrl;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int DIV = 4;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        bit         b2b;
    } exp_t;

    logic       inClk  = 1'b0;
    logic       rst    = 1'b1;
    logic       parOdd = 1'b0;
    logic [1:0] txValid = '0;
    logic [1:0] txReady, txBusy, txOut;
    logic [7:0] txData [2];
    logic [3:0] bitCnt [2];

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    bit   in_frame [2];
    bit   done [2];
    int   cyc [2];
    int   gap [2];
    int   wcnt [2];
    exp_t cur [2];

    always #5 inClk = ~inClk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        uart_tx_ctrl #(.CLK_DIV(DIV), .DATA_W(8), .STOP_BITS(g + 1)) dut (
            .inClk   (inClk),
            .rst     (rst),
            .txData  (txData[g]),
            .txValid (txValid[g]),
`ifdef UART_TX_PARITY_EN
            .parOdd  (parOdd),
`endif
            .txReady (txReady[g]),
            .txBusy  (txBusy[g]),
            .txOut   (txOut[g]),
            .bitCnt  (bitCnt[g])
        );
    end

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t act=%0h exp=%0h", nm, i, $time, act, exp);
        end
    endtask

    // Frame position idx: 0 start, 1..8 data LSB first, 9 parity (if built), then stop.
    function automatic logic exp_bit(exp_t e, int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return e.data[idx-1];
        if (PAR == 1 && idx == 9) return e.pbit;
        return 1'b1;
    endfunction

    task automatic mon_step(int i);
        int fl, idx, qn;
        fl = (10 + PAR + i) * DIV;
        qn = (i == 0) ? q0.size() : q1.size();
        if (!in_frame[i]) begin
            if (done[i]) begin
                chk("ready_after_frame", i, 32'(txReady[i]), 1);
                chk("busy_after_frame", i, 32'(txBusy[i]), 0);
                done[i] = 0;
            end
            wcnt[i] = (qn == 0) ? 0 : wcnt[i] + 1;
            if (txOut[i] === 1'b0 && qn != 0) begin
                cur[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
                if (cur[i].b2b) chk("b2b_gap", i, gap[i], 1);
                in_frame[i] = 1;
                cyc[i] = 0;
            end else if (txOut[i] !== 1'b1) begin
                chk("idle_line", i, 32'(txOut[i]), 1);
            end else if (wcnt[i] > 200) begin
                chk("start_timeout", i, wcnt[i], 200);
                cur[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
                wcnt[i] = 0;
            end else begin
                gap[i]++;
            end
        end
        if (in_frame[i]) begin
            idx = cyc[i] / DIV;
            chk("txOut", i, 32'(txOut[i]), 32'(exp_bit(cur[i], idx)));
            chk("txReady_low", i, 32'(txReady[i]), 0);
            chk("bitCnt", i, 32'(bitCnt[i]), (idx >= 1 && idx <= 8) ? idx - 1 : 0);
            cyc[i]++;
            if (cyc[i] == fl) begin
                in_frame[i] = 0;
                done[i] = 1;
                gap[i] = 0;
            end
        end
    endtask

    always @(negedge inClk or negedge rst) begin
        if (!rst) begin
            #1;
            for (int i = 0; i < 2; i++) begin
                chk("rst_txOut", i, 32'(txOut[i]), 1);
                chk("rst_txReady", i, 32'(txReady[i]), 1);
                chk("rst_bitCnt", i, 32'(bitCnt[i]), 0);
                in_frame[i] = 0;
                done[i] = 0;
                gap[i] = 0;
                wcnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) mon_step(i);
        end
    end

    task automatic send(int i, logic [7:0] d, logic pb, bit b2b, bit hold);
        exp_t e;
        int n = 0;
        e.data = d;
        e.pbit = pb;
        e.b2b  = b2b;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
        txData[i]  = d;
        txValid[i] = 1'b1;
        while (txReady[i] !== 1'b1) begin
            @(negedge inClk);
            n++;
            if (n > 500) begin
                $display("FAIL accept_timeout dut%0d", i);
                $fatal(1, "handshake never completed");
            end
        end
        @(posedge inClk);
        @(negedge inClk);
        if (!hold) txValid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge inClk);
            n++;
        end while ((q0.size() != 0 || q1.size() != 0 || in_frame[0] || in_frame[1]) && n < 2000);
        if (n >= 2000) begin
            $display("FAIL idle_timeout");
            $fatal(1, "frames never drained");
        end
        repeat (3) @(negedge inClk);
    endtask

    initial begin
        int n;
        txData[0] = 8'h00;
        txData[1] = 8'h00;
        #2  rst = 1'b0;
        #20 rst = 1'b1;
        @(negedge inClk);

        // Single frame, 10 bits x 4 cycles.
        send(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Back-to-back frames with txValid held high.
        send(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send(0, 8'hFF, 1'b0, 1'b1, 1'b0);
        wait_idle();

        // Async reset during data bit 3, then a clean frame.
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (bitCnt[0] != 4'd3 && n < 200) begin
            @(negedge inClk);
            n++;
        end
        #1 rst = 1'b0;
        #3 rst = 1'b1;
        @(negedge inClk);
        send(0, 8'h81, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Two stop bits on dut1.
        send(1, 8'h55, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Data changed and valid held while busy.
        send(0, 8'h12, 1'b0, 1'b0, 1'b1);
        txData[0] = 8'hFF;
        repeat (8) @(negedge inClk);
        txValid[0] = 1'b0;
        wait_idle();

`ifdef UART_TX_PARITY_EN
        parOdd = 1'b0;
        send(0, 8'h07, 1'b1, 1'b0, 1'b0);
        wait_idle();
        parOdd = 1'b1;
        send(0, 8'h07, 1'b0, 1'b0, 1'b0);
        wait_idle();
        parOdd = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
